// File: rtl/fifo_ctrl_fsm_pkg.sv
// Shared definitions for the FIFO control stage.
//   DEPTH / AW / CW : FIFO size, pointer width, occupancy width
//   fifo_state_e    : control state codes driven to the address calculator
package fifo_ctrl_fsm_pkg;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_EMPTY = '0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_WRITE    = 3'b001,
        ST_READ     = 3'b010,
        ST_WR_ERROR = 3'b011,
        ST_RD_ERROR = 3'b100
    } fifo_state_e;

endpackage

// File: rtl/fifo_ctrl_fsm_ns.sv
// Next-state function of the FIFO control stage (purely combinational).
//   wr_en, rd_en     : user requests
//   next_data_count  : post-commit occupancy from the address calculator
//   ns               : requested next state
// Simultaneous or absent requests fall back to IDLE without an error.
module fifo_ns
    import fifo_ctrl_fsm_pkg::*;
(
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [CW-1:0] next_data_count,
    output fifo_state_e   ns
);

    always_comb begin
        ns = ST_IDLE;
        if (wr_en && !rd_en) begin
            ns = (next_data_count == CNT_FULL) ? ST_WR_ERROR : ST_WRITE;
        end else if (rd_en && !wr_en) begin
            ns = (next_data_count == CNT_EMPTY) ? ST_RD_ERROR : ST_READ;
        end
    end

endmodule

// File: rtl/fifo_ctrl_fsm.sv
// Registered control stage of the 8-entry FIFO.
//   clk, reset_n         : clock, synchronous active-low reset
//   wr_en, rd_en         : user requests
//   clr_err              : clears sticky overflow/underflow flags
//   next_head/tail/count : values from the address calculator, loaded every edge
//   state, head, tail,
//   data_count           : registers fed back to the address calculator
//   full, empty          : occupancy decode
//   wr_ack/wr_err,
//   rd_ack/rd_err        : per-cycle handshake decode of the state register
//   ovf_sticky/unf_sticky: latched error history
// Every output is a decode of registers only, so there is no input-to-output path.
module fifo_ctrl_fsm
    import fifo_ctrl_fsm_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic          clr_err,
    input  logic [AW-1:0] next_head,
    input  logic [AW-1:0] next_tail,
    input  logic [CW-1:0] next_data_count,
    output logic [2:0]    state,
    output logic [AW-1:0] head,
    output logic [AW-1:0] tail,
    output logic [CW-1:0] data_count,
    output logic          full,
    output logic          empty,
    output logic          wr_ack,
    output logic          wr_err,
    output logic          rd_ack,
    output logic          rd_err,
    output logic          ovf_sticky,
    output logic          unf_sticky
);

    fifo_state_e   state_q, state_d, ns;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          legal;

    fifo_ns u_ns (
        .wr_en           (wr_en),
        .rd_en           (rd_en),
        .next_data_count (next_data_count),
        .ns              (ns)
    );

    always_comb begin
        legal = 1'b0;
        case (state_q)
            ST_IDLE, ST_WRITE, ST_READ, ST_WR_ERROR, ST_RD_ERROR: legal = 1'b1;
            default:                                              legal = 1'b0;
        endcase
    end

    // An illegal state code recovers to IDLE and freezes the pointers so a
    // corrupted state cannot also corrupt the occupancy bookkeeping.
    always_comb begin
        state_d = ns;
        head_d  = next_head;
        tail_d  = next_tail;
        cnt_d   = next_data_count;
        if (!legal) begin
            state_d = ST_IDLE;
            head_d  = head_q;
            tail_d  = tail_q;
            cnt_d   = cnt_q;
        end
    end

    // Set has priority over clear.
    always_comb begin
        ovf_d = (state_q == ST_WR_ERROR) || (ovf_q && !clr_err);
        unf_d = (state_q == ST_RD_ERROR) || (unf_q && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign state      = state_q;
    assign head       = head_q;
    assign tail       = tail_q;
    assign data_count = cnt_q;
    assign full       = (cnt_q == CNT_FULL);
    assign empty      = (cnt_q == CNT_EMPTY);
    assign wr_ack     = (state_q == ST_WRITE);
    assign wr_err     = (state_q == ST_WR_ERROR);
    assign rd_ack     = (state_q == ST_READ);
    assign rd_err     = (state_q == ST_RD_ERROR);
    assign ovf_sticky = ovf_q;
    assign unf_sticky = unf_q;

endmodule
